debug_uart_tx: RTL and testbench

Buffered UART transmitter on the debug peripheral's host-bound path. The debug command logic pushes response bytes (ping replies, PC and register dumps) through a valid/ready write port into an internal byte FIFO. The block serializes them as 8N1 frames on the host-facing TX line. It absorbs multi-byte bursts from a single command with no per-byte handshaking against frame completion.

---
 rtl/debug_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_debug_uart_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// Buffered 8N1 UART transmitter with byte FIFO for the debug host path.
// Define DEBUG_UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module debug_uart_tx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_N,
  input  logic                     i_Tx_DV,
  input  logic [7:0]               i_Tx_Byte,
  output logic                     o_Tx_Ready,
  output logic                     o_Tx_Serial,
  output logic                     o_Tx_Busy,
  output logic                     o_Tx_Done,
  output logic [FIFO_DEPTH_LOG2:0] o_Fifo_Count,
  output logic                     o_Overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int AW    = FIFO_DEPTH_LOG2;

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    s_IDLE,
    s_START,
    s_DATA,
`ifdef DEBUG_UART_TX_PARITY_EN
    s_PARITY,
`endif
    s_STOP
  } state_t;

  logic [7:0]    r_Mem [DEPTH];
  logic [AW-1:0] r_Wr_Ptr;
  logic [AW-1:0] r_Rd_Ptr;
  logic [AW:0]   r_Count;
  logic          r_Overflow;

  state_t        r_State;
  state_t        w_State_Next;
  logic [CW-1:0] r_Clk_Cnt;
  logic [2:0]    r_Bit_Idx;
  logic [7:0]    r_Shift;

  logic w_Full;
  logic w_Empty;
  logic w_Push;
  logic w_Pop;
  logic w_Clk_Last;
  logic w_Serial;
  logic w_Done;

  assign w_Full     = (r_Count == FULL);
  assign w_Empty    = (r_Count == '0);
  assign w_Push     = i_Tx_DV && !w_Full;
  assign w_Clk_Last = (r_Clk_Cnt == LAST);

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset_N && w_Push)
      r_Mem[r_Wr_Ptr] <= i_Tx_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      r_Wr_Ptr   <= '0;
      r_Rd_Ptr   <= '0;
      r_Count    <= '0;
      r_Overflow <= 1'b0;
    end else begin
      if (w_Push)
        r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      if (w_Pop)
        r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      if (i_Tx_DV && w_Full)
        r_Overflow <= 1'b1;
      unique case ({w_Push, w_Pop})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase
    end
  end

  always_comb begin
    w_State_Next = r_State;
    w_Pop        = 1'b0;
    w_Done       = 1'b0;
    w_Serial     = 1'b1;
    unique case (r_State)
      s_IDLE: begin
        if (!w_Empty) begin
          w_Pop        = 1'b1;
          w_State_Next = s_START;
        end
      end
      s_START: begin
        w_Serial = 1'b0;
        if (w_Clk_Last)
          w_State_Next = s_DATA;
      end
      s_DATA: begin
        w_Serial = r_Shift[r_Bit_Idx];
        if (w_Clk_Last && r_Bit_Idx == 3'd7)
`ifdef DEBUG_UART_TX_PARITY_EN
          w_State_Next = s_PARITY;
`else
          w_State_Next = s_STOP;
`endif
      end
`ifdef DEBUG_UART_TX_PARITY_EN
      s_PARITY: begin
        w_Serial = ^r_Shift;
        if (w_Clk_Last)
          w_State_Next = s_STOP;
      end
`endif
      s_STOP: begin
        if (w_Clk_Last) begin
          w_Done = 1'b1;
          // Chain straight into the next start bit when data waits.
          if (!w_Empty) begin
            w_Pop        = 1'b1;
            w_State_Next = s_START;
          end else begin
            w_State_Next = s_IDLE;
          end
        end
      end
      default: w_State_Next = s_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      r_State   <= s_IDLE;
      r_Clk_Cnt <= '0;
      r_Bit_Idx <= '0;
      r_Shift   <= '0;
    end else begin
      r_State <= w_State_Next;
      if (w_State_Next != r_State || w_Clk_Last)
        r_Clk_Cnt <= '0;
      else
        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
      if (r_State == s_DATA && w_Clk_Last)
        r_Bit_Idx <= r_Bit_Idx + 1'b1;
      if (w_Pop)
        r_Shift <= r_Mem[r_Rd_Ptr];
    end
  end

  assign o_Tx_Serial  = w_Serial;
  assign o_Tx_Busy    = (r_State != s_IDLE);
  assign o_Tx_Done    = w_Done;
  assign o_Tx_Ready   = !w_Full;
  assign o_Fifo_Count = r_Count;
  assign o_Overflow   = r_Overflow;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Self-checking bench for debug_uart_tx against a frame-level model.
// Honours DEBUG_UART_TX_PARITY_EN for the expected frame format.
module tb_debug_uart_tx;

  localparam int C     = 4;
  localparam int LG    = 4;
  localparam int DEPTH = 1 << LG;
`ifdef DEBUG_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL   = NB * C;
  localparam int MAXT = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  tx_byte = 8'h00;
  logic        ready;
  logic        serial;
  logic        busy;
  logic        done;
  logic [LG:0] cnt;
  logic        ovf;

  debug_uart_tx #(
    .CLKS_PER_BIT   (C),
    .FIFO_DEPTH_LOG2(LG)
  ) dut (
    .i_Clock     (clk),
    .i_Reset_N   (rst_n),
    .i_Tx_DV     (dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Ready  (ready),
    .o_Tx_Serial (serial),
    .o_Tx_Busy   (busy),
    .o_Tx_Done   (done),
    .o_Fifo_Count(cnt),
    .o_Overflow  (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int         wr_t[$];
  logic [7:0] wr_b[$];

  logic e_line[MAXT];
  logic e_busy[MAXT];
  logic e_done[MAXT];
  logic e_ovf[MAXT];
  int   e_cnt[MAXT];
  logic a_line[MAXT];
  logic a_busy[MAXT];
  logic a_done[MAXT];
  int   a_cnt[MAXT];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dv = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    logic r;
    if (i == 0) r = 1'b0;
    else if (i <= 8) r = b[i-1];
    else if (NB == 11 && i == 9) r = ^b;
    else r = 1'b1;
    return r;
  endfunction

  // Byte-level model: FIFO as a queue, line free again FL cycles after a pop.
  task automatic build_model(input int T);
    logic [7:0] mq[$];
    int         fp = -1;
    logic [7:0] fb = 8'h00;
    int         free_at = 0;
    logic       ovf_m = 1'b0;
    int         wi = 0;
    int         occ;
    for (int t = 0; t < T; t++) begin
      occ = mq.size();
      if (occ > 0 && t >= free_at) begin
        fp = t;
        fb = mq.pop_front();
        free_at = t + FL;
      end
      if (wi < wr_t.size() && wr_t[wi] == t) begin
        if (occ < DEPTH) mq.push_back(wr_b[wi]);
        else ovf_m = 1'b1;
        wi++;
      end
      e_cnt[t] = mq.size();
      e_ovf[t] = ovf_m;
      if (fp >= 0 && t < fp + FL) begin
        e_line[t] = frame_bit(fb, (t - fp) / C);
        e_busy[t] = 1'b1;
        e_done[t] = (t == fp + FL - 1);
      end else begin
        e_line[t] = 1'b1;
        e_busy[t] = 1'b0;
        e_done[t] = 1'b0;
      end
    end
  endtask

  task automatic run_sched(input string name, input int T);
    int wi = 0;
    bit bl = 0, bb = 0, bd = 0, bc = 0, bo = 0, br = 0;
    build_model(T);
    for (int t = 0; t < T; t++) begin
      if (wi < wr_t.size() && wr_t[wi] == t) begin
        dv = 1'b1;
        tx_byte = wr_b[wi];
        wi++;
      end else begin
        dv = 1'b0;
        tx_byte = 8'($urandom);
      end
      tick();
      a_line[t] = serial;
      a_busy[t] = busy;
      a_done[t] = done;
      a_cnt[t] = int'(cnt);
      if (serial !== e_line[t] && !bl) begin
        bl = 1;
        $display("FAIL %s line t=%0d got %b want %b", name, t, serial, e_line[t]);
      end
      if (busy !== e_busy[t] && !bb) begin
        bb = 1;
        $display("FAIL %s busy t=%0d got %b want %b", name, t, busy, e_busy[t]);
      end
      if (done !== e_done[t] && !bd) begin
        bd = 1;
        $display("FAIL %s done t=%0d got %b want %b", name, t, done, e_done[t]);
      end
      if (cnt !== (LG+1)'(e_cnt[t]) && !bc) begin
        bc = 1;
        $display("FAIL %s count t=%0d got %0d want %0d", name, t, cnt, e_cnt[t]);
      end
      if (ovf !== e_ovf[t] && !bo) begin
        bo = 1;
        $display("FAIL %s overflow t=%0d got %b want %b", name, t, ovf, e_ovf[t]);
      end
      if (ready !== (e_cnt[t] < DEPTH) && !br) begin
        br = 1;
        $display("FAIL %s ready t=%0d got %b want %b", name, t, ready, e_cnt[t] < DEPTH);
      end
    end
    dv = 1'b0;
    checks += 6;
    failures += int'(bl) + int'(bb) + int'(bd) + int'(bc) + int'(bo) + int'(br);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dv = 1'b1;
    tx_byte = 8'($urandom);
    tick();
    tick();
    checks += 6;
    if (serial !== 1'b1) begin failures++; $display("FAIL rst_serial got %b want 1", serial); end
    if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b want 1", ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", done); end
    if (cnt !== '0) begin failures++; $display("FAIL rst_count got %0d want 0", cnt); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got %b want 0", ovf); end
    dv = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_a5();
    int np = 0, nb = 0;
    do_reset();
    wr_t = {0};
    wr_b = {8'hA5};
    run_sched("single_a5", FL + 12);
    for (int t = 0; t < FL + 12; t++) begin
      np += int'(a_done[t]);
      nb += int'(a_busy[t]);
    end
    checks += 4;
    if (a_line[1] !== 1'b0) begin failures++; $display("FAIL a5_start got %b want 0", a_line[1]); end
    if (np !== 1) begin failures++; $display("FAIL a5_done_pulses got %0d want 1", np); end
    if (a_done[FL] !== 1'b1) begin failures++; $display("FAIL a5_done_time got %b want 1", a_done[FL]); end
    if (nb !== FL) begin failures++; $display("FAIL a5_busy_cycles got %0d want %0d", nb, FL); end
  endtask

  task automatic test_burst();
    do_reset();
    wr_t = {};
    wr_b = {};
    for (int i = 0; i < 18; i++) begin
      wr_t.push_back(i);
      wr_b.push_back(8'(i));
    end
    run_sched("burst", 17 * FL + 12);
    checks += 2;
    if (a_cnt[16] !== DEPTH) begin failures++; $display("FAIL burst_full got %0d want %0d", a_cnt[16], DEPTH); end
    if (ovf !== 1'b1) begin failures++; $display("FAIL burst_ovf got %b want 1", ovf); end
  endtask

  task automatic test_back_to_back();
    int nb = 0;
    do_reset();
    wr_t = {0, 1};
    wr_b = {8'h00, 8'hFF};
    run_sched("b2b", 2 * FL + 12);
    for (int t = 0; t < 2 * FL + 12; t++) nb += int'(a_busy[t]);
    checks++;
    if (nb !== 2 * FL) begin failures++; $display("FAIL b2b_busy got %0d want %0d", nb, 2 * FL); end
  endtask

  task automatic test_simul_write_pop();
    do_reset();
    wr_t = {0, 1, 2, 3, FL + 1};
    wr_b = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_sched("simul", 5 * FL + 12);
    checks += 2;
    if (a_cnt[FL] !== 3) begin failures++; $display("FAIL simul_pre got %0d want 3", a_cnt[FL]); end
    if (a_cnt[FL+1] !== 3) begin failures++; $display("FAIL simul_post got %0d want 3", a_cnt[FL+1]); end
  endtask

  task automatic test_reset_mid_frame();
    int nd = 0, nl = 0;
    do_reset();
    dv = 1'b1;
    tx_byte = 8'h3C;
    tick();
    tx_byte = 8'h11;
    tick();
    dv = 1'b0;
    repeat (21) tick();
    checks += 2;
    if (serial !== 1'b1) begin failures++; $display("FAIL mid_bit4 got %b want 1", serial); end
    if (cnt !== 1) begin failures++; $display("FAIL mid_count got %0d want 1", cnt); end
    rst_n = 1'b0;
    dv = 1'b1;
    tx_byte = 8'($urandom);
    tick();
    checks += 4;
    if (serial !== 1'b1) begin failures++; $display("FAIL mrst_serial got %b want 1", serial); end
    if (cnt !== '0) begin failures++; $display("FAIL mrst_count got %0d want 0", cnt); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL mrst_ovf got %b want 0", ovf); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mrst_busy got %b want 0", busy); end
    rst_n = 1'b1;
    dv = 1'b0;
    for (int t = 0; t < 3 * FL; t++) begin
      tick();
      nd += int'(done);
      nl += int'(!serial);
    end
    checks += 2;
    if (nd !== 0) begin failures++; $display("FAIL mrst_no_done got %0d want 0", nd); end
    if (nl !== 0) begin failures++; $display("FAIL mrst_idle_line got %0d want 0", nl); end
    wr_t = {0};
    wr_b = {8'h55};
    run_sched("after_rst_55", FL + 12);
  endtask

  task automatic test_random();
    int n, t, tlast;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      wr_t = {};
      wr_b = {};
      n = $urandom_range(20, 1);
      t = $urandom_range(3, 0);
      for (int i = 0; i < n; i++) begin
        wr_t.push_back(t);
        wr_b.push_back(8'($urandom));
        t += 1 + $urandom_range(FL, 0) * $urandom_range(1, 0);
      end
      tlast = wr_t[n-1];
      run_sched($sformatf("random%0d", it), tlast + (n + 1) * FL + 10);
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_burst();
    test_back_to_back();
    test_simul_write_pop();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
